// File: rtl/ram_stream_reader.sv
// Read-side sequencer for the single-port sample RAM: walks a wrapping address
// window and streams each word out over a valid/ready handshake.
module ram_stream_reader #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [N-1:0]         base_addr,
  input  logic [N:0]           length,
  input  logic                 loop,
  input  logic                 abort,
  output logic [N-1:0]         ram_add,
  input  logic [BIT_WIDTH-1:0] ram_dout,
  output logic [BIT_WIDTH-1:0] sample,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 sample_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } state_t;

  localparam logic [N:0] DEPTH = {1'b1, {N{1'b0}}};

  state_t               r_state;
  logic [N-1:0]         r_ptr;
  logic [N-1:0]         r_base;
  logic [N:0]           r_len;
  logic [N:0]           r_count;
  logic                 r_loop;
  logic [BIT_WIDTH-1:0] r_sample;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_busy;
  logic                 r_done;

  logic [N:0]           w_len_sat;
  logic                 w_load;
  logic                 w_last_word;
  logic [N-1:0]         w_ptr_next;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_len_sat = length;
    if (length > DEPTH) w_len_sat = DEPTH;
  end

  // The output register can take a new word when empty or being drained now.
  assign w_load      = !r_valid || sample_ready;
  assign w_last_word = (r_count == r_len - 1'b1);
  assign w_ptr_next  = r_ptr + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_base   <= '0;
      r_len    <= '0;
      r_count  <= '0;
      r_loop   <= 1'b0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (abort) begin
      // Abort outranks start and the handshake; the held word is discarded.
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start && (length != '0)) begin
            r_base  <= base_addr;
            r_len   <= w_len_sat;
            r_loop  <= loop;
            r_ptr   <= base_addr;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (w_load) begin
            r_sample <= ram_dout;
            r_valid  <= 1'b1;
            r_last   <= w_last_word;
            if (w_last_word && r_loop) begin
              // Restart the window on the same edge so looping has no bubble.
              r_ptr   <= r_base;
              r_count <= '0;
            end else begin
              r_ptr   <= w_ptr_next;
              r_count <= r_count + 1'b1;
              if (w_last_word) r_state <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end
        end

        ST_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_add      = r_ptr;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign sample_last  = r_last;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: one-shot, backpressure, wrap/loop,
// abort, length boundaries and asynchronous reset, against a local RAM model.
module tb_ram_stream_reader;

  localparam int BW = 16;
  localparam int N  = 9;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [N-1:0]  base_addr;
  logic [N:0]    length;
  logic          loop;
  logic          abort;
  logic [N-1:0]  ram_add;
  logic [BW-1:0] ram_dout;
  logic [BW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          sample_last;
  logic          busy;
  logic          done;

  logic [BW-1:0] mem [0:(1<<N)-1];

  int total;
  int bad;

  ram_stream_reader #(.BIT_WIDTH(BW), .N(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .loop         (loop),
    .abort        (abort),
    .ram_add      (ram_add),
    .ram_dout     (ram_dout),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_last  (sample_last),
    .busy         (busy),
    .done         (done)
  );

  assign ram_dout = mem[ram_add];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: A0..A3 at 20..23, 0x1000+addr everywhere else.
  function automatic logic [BW-1:0] word_at(input int a);
    if (a >= 20 && a <= 23) return BW'(16'h00A0 + a - 20);
    return BW'(16'h1000 + a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int b, input int len, input logic lp);
    start     = 1'b1;
    base_addr = N'(b);
    length    = (N+1)'(len);
    loop      = lp;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int k;
    int errs;
    logic [BW-1:0] wrap_exp [3];

    total = 0;
    bad   = 0;
    for (int i = 0; i < (1 << N); i++) mem[i] = word_at(i);

    reset_n      = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    length       = '0;
    loop         = 1'b0;
    abort        = 1'b0;
    sample_ready = 1'b1;
    #12;
    check("rst_add",   32'(ram_add), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_last",  32'(sample_last), 0);
    check("rst_sample", 32'(sample), 0);
    reset_n = 1'b1;
    tick();

    // One-shot, ready held high: first word valid two edges after start is driven.
    issue(20, 4, 1'b0);
    check("os_busy0",  32'(busy), 1);
    check("os_valid0", 32'(sample_valid), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("os_valid", 32'(sample_valid), 1);
      check("os_data",  32'(sample), 32'(16'h00A0 + i));
      check("os_last",  32'(sample_last), (i == 3) ? 1 : 0);
      check("os_add",   32'(ram_add), 32'(21 + i));
      check("os_nodone", 32'(done), 0);
    end
    tick();
    check("os_done",   32'(done), 1);
    check("os_busyf",  32'(busy), 1);
    check("os_valid1", 32'(sample_valid), 0);
    tick();
    check("os_done0",  32'(done), 0);
    check("os_busy1",  32'(busy), 0);

    // Backpressure while A1 is valid.
    issue(20, 4, 1'b0);
    tick();
    check("bp_a0", 32'(sample), 32'h00A0);
    tick();
    check("bp_a1", 32'(sample), 32'h00A1);
    sample_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data",  32'(sample), 32'h00A1);
      check("bp_hold_valid", 32'(sample_valid), 1);
      check("bp_hold_add",   32'(ram_add), 22);
      check("bp_hold_last",  32'(sample_last), 0);
    end
    sample_ready = 1'b1;
    tick();
    check("bp_a2", 32'(sample), 32'h00A2);
    tick();
    check("bp_a3",   32'(sample), 32'h00A3);
    check("bp_last", 32'(sample_last), 1);
    tick();
    check("bp_done",  32'(done), 1);
    check("bp_valid", 32'(sample_valid), 0);
    tick();
    check("bp_idle", 32'(busy), 0);

    // Wrap and loop, with a stray start mid-stream, then abort.
    wrap_exp[0] = 16'h11FE;
    wrap_exp[1] = 16'h11FF;
    wrap_exp[2] = 16'h1000;
    issue(510, 3, 1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        start     = 1'b1;
        base_addr = N'(100);
        length    = (N+1)'(5);
        loop      = 1'b0;
      end
      tick();
      start = 1'b0;
      check("lp_valid", 32'(sample_valid), 1);
      check("lp_data",  32'(sample), 32'(wrap_exp[i % 3]));
      check("lp_last",  32'(sample_last), (i % 3 == 2) ? 1 : 0);
      check("lp_nodone", 32'(done), 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", 32'(sample_valid), 0);
    check("ab_last",  32'(sample_last), 0);
    check("ab_busy",  32'(busy), 0);
    check("ab_done",  32'(done), 0);
    tick();
    check("ab_done2", 32'(done), 0);

    // Zero length is ignored.
    issue(7, 0, 1'b0);
    check("z_busy", 32'(busy), 0);
    tick();
    check("z_busy2", 32'(busy), 0);
    check("z_done",  32'(done), 0);

    // Oversized length saturates to the full RAM, every address once.
    issue(0, 600, 1'b0);
    k    = 0;
    errs = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      tick();
      if (sample_valid && sample_ready && !done) begin
        if (sample !== word_at(k)) errs++;
        if (sample_last !== ((k == 511) ? 1'b1 : 1'b0)) errs++;
        k++;
      end
    end
    check("sat_words", 32'(k), 512);
    check("sat_errs",  32'(errs), 0);
    check("sat_done",  32'(done), 1);
    tick();
    check("sat_idle", 32'(busy), 0);

    // Asynchronous reset between edges mid-stream.
    issue(20, 4, 1'b0);
    tick();
    check("ar_pre", 32'(sample_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid",  32'(sample_valid), 0);
    check("ar_busy",   32'(busy), 0);
    check("ar_add",    32'(ram_add), 0);
    check("ar_sample", 32'(sample), 0);
    #2;
    reset_n = 1'b1;
    tick();
    issue(5, 1, 1'b0);
    tick();
    check("r5_data",  32'(sample), 32'h1005);
    check("r5_valid", 32'(sample_valid), 1);
    check("r5_last",  32'(sample_last), 1);
    tick();
    check("r5_done",  32'(done), 1);
    tick();
    check("r5_idle",  32'(busy), 0);
    check("r5_done0", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
